// File: rtl/signed_sat_accumulator.sv
// signed_sat_accumulator: framed saturating add/sub accumulator with valid/ready on both sides; optional SAT_ACC_BYPASS_EN overlaps frame hand-off with the next sample
module signed_sat_accumulator #(
  parameter int W = 4,
  parameter int N_SAMPLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_sat
);
  localparam int CW = $clog2(N_SAMPLES + 1);
  localparam logic [0:0] ACC = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]  state;
  logic [W-1:0] acc, base_acc, nacc;
  logic [CW-1:0] cnt, ncnt;
  logic sat_flag, nsat, ovf, last, in_xfer, out_xfer;
  logic [W:0] r;
  assign out_valid = state == HOLD;
`ifdef SAT_ACC_BYPASS_EN
  assign in_ready = state == ACC || out_ready;
`else
  assign in_ready = state == ACC;
`endif
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  // next accumulator value; a sample taken in HOLD starts a fresh frame from zero
  always_comb begin
    base_acc = state == HOLD ? '0 : acc;
    r = in_sub ? {base_acc[W-1], base_acc} - {in_data[W-1], in_data}
               : {base_acc[W-1], base_acc} + {in_data[W-1], in_data};
    ovf = r[W] != r[W-1];
    nacc = ovf ? (r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : r[W-1:0];
    nsat = (state == HOLD ? 1'b0 : sat_flag) | ovf;
    ncnt = (state == HOLD ? '0 : cnt) + 1'b1;
    last = ncnt == CW'(N_SAMPLES);
  end
  // frame sequencing, accumulation and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc <= '0;
      cnt <= '0;
      sat_flag <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else if (in_xfer) begin
      acc <= nacc;
      cnt <= ncnt;
      sat_flag <= nsat;
      state <= last ? HOLD : ACC;
      out_data <= last ? nacc : out_data;
      out_sat <= last ? nsat : out_sat;
    end else if (out_xfer) begin
      acc <= '0;
      cnt <= '0;
      sat_flag <= 1'b0;
      state <= ACC;
    end
  end
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb_signed_sat_accumulator: directed self-checking bench for signed_sat_accumulator
module tb_signed_sat_accumulator;
  logic clk = 0, rst = 1, in_valid = 0, in_sub = 0, out_ready = 0;
  logic [3:0] in_data = 0;
  logic in_ready, out_valid, out_sat;
  logic [3:0] out_data;
  int n_checks = 0, n_fail = 0;

  signed_sat_accumulator #(.W(4), .N_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [3:0] d, input logic s);
    int k = 0;
    @(negedge clk);
    in_valid = 1; in_data = d; in_sub = s;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end else @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic collect();
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL rst_out_data got %0h want 0", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_out_sat got %0b want 0", out_sat); end
  endtask

  task automatic test_add();
    send(4'd3, 0); send(4'd2, 0); send(4'd1, 0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %0b want 0", out_valid); end
    send(4'd1, 0);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0b want 1", out_valid); end
    n_checks++; if (out_data !== 4'd7) begin n_fail++; $display("FAIL add_data got %0h want 7", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL add_sat got %0b want 0", out_sat); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_hold_ready got %0b want 0", in_ready); end
    collect();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_pos_sat();
    send(4'd4, 0); send(4'd4, 0); send(4'd4, 0); send(4'hF, 0);
    @(negedge clk);
    n_checks++; if (out_data !== 4'd6) begin n_fail++; $display("FAIL pos_sat_data got %0h want 6", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL pos_sat_flag got %0b want 1", out_sat); end
    collect();
  endtask

  task automatic test_neg_sat();
    send(4'd3, 1); send(4'd5, 1); send(4'd2, 1); send(4'd1, 0);
    @(negedge clk);
    n_checks++; if (out_data !== 4'h9) begin n_fail++; $display("FAIL neg_sat_data got %0h want 9", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL neg_sat_flag got %0b want 1", out_sat); end
    collect();
    repeat (4) send(4'd1, 0);
    @(negedge clk);
    n_checks++; if (out_data !== 4'd4) begin n_fail++; $display("FAIL flag_clear_data got %0h want 4", out_data); end
    n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL flag_clear_sat got %0b want 0", out_sat); end
    collect();
  endtask

  task automatic test_sub_min();
    send(4'h8, 1); send(4'd0, 0); send(4'd0, 0); send(4'd0, 0);
    @(negedge clk);
    n_checks++; if (out_data !== 4'd7) begin n_fail++; $display("FAIL sub_min_data got %0h want 7", out_data); end
    n_checks++; if (out_sat !== 1'b1) begin n_fail++; $display("FAIL sub_min_sat got %0b want 1", out_sat); end
    collect();
  endtask

  task automatic test_hold_stall();
    repeat (4) send(4'd1, 0);
    @(negedge clk);
    in_valid = 1; in_data = 4'd3; in_sub = 0; out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %0b want 0", i, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || out_data !== 4'd4 || out_sat !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got v=%0b d=%0h s=%0b want v=1 d=4 s=0", i, out_valid, out_data, out_sat);
      end
    end
    in_valid = 0;
    collect();
    send(4'd2, 0); send(4'd0, 0); send(4'd0, 0); send(4'd0, 0);
    @(negedge clk);
    n_checks++; if (out_data !== 4'd2) begin n_fail++; $display("FAIL stall_no_consume got %0h want 2", out_data); end
    collect();
  endtask

  task automatic test_mid_reset();
    send(4'd5, 0); send(4'd1, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'd0) begin
      n_fail++; $display("FAIL mid_rst_state got v=%0b r=%0b d=%0h want v=0 r=1 d=0", out_valid, in_ready, out_data);
    end
    send(4'd1, 0); send(4'd1, 0); send(4'd1, 0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_early_valid got %0b want 0", out_valid); end
    send(4'd1, 0);
    @(negedge clk);
    n_checks++; if (out_data !== 4'd4 || out_sat !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_frame got d=%0h s=%0b want d=4 s=0", out_data, out_sat);
    end
    collect();
  endtask

`ifdef SAT_ACC_BYPASS_EN
  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1; in_data = 4'd1; in_sub = 0; out_ready = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== (k % 4 == 0)) begin n_fail++; $display("FAIL b2b_valid[%0d] got %0b want %0b", k, out_valid, k % 4 == 0); end
      if (k % 4 == 0) begin
        n_checks++; if (out_data !== 4'd4 || out_sat !== 1'b0) begin
          n_fail++; $display("FAIL b2b_data[%0d] got d=%0h s=%0b want d=4 s=0", k, out_data, out_sat);
        end
      end
    end
    in_valid = 0; out_ready = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_pos_sat();
    test_neg_sat();
    test_sub_min();
    test_hold_stall();
    test_mid_reset();
`ifdef SAT_ACC_BYPASS_EN
    test_reset();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/signed_sat_accumulator.md
Name: signed_sat_accumulator

Overview:
- Streaming signed accumulator. Each accepted sample is added to, or subtracted from, a running sum, with saturation to the signed W-bit range.
- After N_SAMPLES accepted samples, the block presents the final sum downstream and clears itself for the next frame.
- Counterpart to the combinational saturating adder: it covers the subtract direction and the sequential framing needed around it.
- Sits between a sample producer and a consumer, with valid/ready on both sides.

Parameters:
- W, 4, data width in bits; two's-complement signed.
- N_SAMPLES, 4, samples per frame; must be >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a sample.
- in_ready  output  1  block can accept a sample.
- in_data  input  W  signed sample.
- in_sub  input  1  1 = subtract in_data from the sum; 0 = add.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  signed frame result.
- out_sat  output  1  saturation occurred at least once in this frame.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at a clock edge):
  - state=ACC, acc=0, cnt=0, sat_flag=0.
  - out_valid=0, out_data=0, out_sat=0, in_ready=1 on the following cycle.
  - Reset overrides every other event, including mid-frame and mid-HOLD. A partial frame is discarded with no output.
- Input transfer: occurs on a clock edge where in_valid && in_ready.
- Output transfer: occurs on a clock edge where out_valid && out_ready.
- Arithmetic on each input transfer:
  - Extend acc and in_data to W+1 bits.
  - Compute r = acc + in_data, or r = acc - in_data when in_sub=1.
  - If r > 2^(W-1)-1, the new acc = 2^(W-1)-1 and sat_flag is set.
  - If r < -2^(W-1), the new acc = -2^(W-1) and sat_flag is set.
  - Otherwise the new acc = r[W-1:0].
  - Subtracting the most negative value (e.g. 0 - (-8) at W=4) saturates to the maximum (+7).
- State ACC:
  - in_ready=1, out_valid=0.
  - On an input transfer: update acc per the arithmetic rule; cnt <= cnt+1.
  - If this transfer is sample number N_SAMPLES, go to HOLD and load out_data=new acc and out_sat=new sat_flag, both registered.
- State HOLD:
  - out_valid=1, in_ready=0 (baseline); in_valid is ignored.
  - out_data and out_sat are held stable until the output transfer.
  - On the output transfer: acc=0, cnt=0, sat_flag=0; go to ACC; out_valid drops next cycle.
- Latency: out_valid rises on the cycle after the N_SAMPLES-th input transfer.
- Throughput (baseline): N_SAMPLES+1 cycles per frame minimum.
- cnt width: clog2(N_SAMPLES+1). No wrap is possible because cnt is cleared on entry to ACC.
- in_sub is sampled only on an input transfer.
- Outputs are all registered; no combinational path from in_* to out_*. in_ready depends only on state (baseline).

Optional Feature:
- Macro: SAT_ACC_BYPASS_EN.
- Defined:
  - In HOLD, in_ready = out_ready.
  - An input transfer coinciding with the output transfer becomes sample 1 of the next frame: acc = sat(0 ± in_data), cnt=1, sat_flag per that single operation.
  - Sustained throughput becomes N_SAMPLES cycles per frame.
  - If N_SAMPLES=1, that sample completes the frame immediately: stay in HOLD with the new result loaded.
- Undefined: baseline behaviour, in_ready=0 throughout HOLD.

Test Plan:
- Add 3,2,1,1 (in_sub=0), out_ready=1 -> one cycle after the 4th transfer: out_valid=1, out_data=7, out_sat=0.
- Add 4,4,4 then add -1 -> acc sequence 4,7,7,6 -> out_data=6, out_sat=1.
- Sub 3, sub 5, sub 2, add 1 -> acc sequence -3,-8,-8,-7 -> out_data=-7, out_sat=1. Then a second frame of add 1 x4 -> out_data=4, out_sat=0 (flag cleared).
- Sub -8, then add 0 x3 -> out_data=7, out_sat=1.
- out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0 and out_data/out_sat stable all 5 cycles. Baseline: no sample consumed. With SAT_ACC_BYPASS_EN: still none consumed, since out_ready=0.
- rst pulsed after 2 samples (add 5, add 1), then add 1 x4 -> out_data=4, out_sat=0, no output from the aborted frame.
- SAT_ACC_BYPASS_EN: in_valid and out_ready held high continuously -> out_valid asserts every 4 cycles with correct sums.
